// File: rtl/ym3438_reg_file_gen_if.sv
// ym3438_reg_file_gen_if: CPU-side write bus of the YM3438 register file.
// addr_wr/data_wr/bank/din flow to the slave; busy/ovf report back.
interface ym3438_reg_file_gen_if;
  logic       addr_wr;
  logic       data_wr;
  logic       bank;
  logic [7:0] din;
  logic       busy;
  logic       ovf;

  modport master (
    output addr_wr, data_wr, bank, din,
    input  busy, ovf
  );

  modport slave (
    input  addr_wr, data_wr, bank, din,
    output busy, ovf
  );
endinterface

// File: rtl/ym3438_reg_file_gen.sv
// ym3438_reg_file_gen: YM3438 operator/channel register file, slot-timed commit.
// Ports: MCLK, rst (async, active high); slot_en/slot_sync step the slot
// counter; bus (addr_wr, data_wr, bank, din, busy, ovf) is the CPU write
// port; slot, op_regs, ch_fnum, ch_block, ch_b0, ch_b4 show the current
// slot's stored registers. Define YM3438_REG_READBACK_EN to add
// rd_req/rd_data readback of the byte at the latched address.
module ym3438_reg_file_gen #(
  parameter  int NUM_CH = 6,
  parameter  int NSLOT  = 4 * NUM_CH,
  localparam int SW     = $clog2(NSLOT)
) (
  input  logic          MCLK,
  input  logic          rst,
  input  logic          slot_en,
  input  logic          slot_sync,
  ym3438_reg_file_gen_if.slave bus,
  output logic [SW-1:0] slot,
  output logic [55:0]   op_regs,
  output logic [10:0]   ch_fnum,
  output logic [2:0]    ch_block,
  output logic [5:0]    ch_b0,
  output logic [7:0]    ch_b4
`ifdef YM3438_REG_READBACK_EN
  ,
  input  logic          rd_req,
  output logic [7:0]    rd_data
`endif
);

  localparam int CPB = NUM_CH / 2;
  localparam int CW  = $clog2(NUM_CH);

  function automatic logic [3:0] f_ch(input logic [8:0] a);
    return (a[8] ? 4'(CPB) : 4'd0) + {2'b00, a[1:0]};
  endfunction

  function automatic logic f_ok(input logic [8:0] a);
    return (a[1:0] != 2'd3) && (f_ch(a) < 4'(NUM_CH));
  endfunction

  // operator index is {a[2], a[3]}: register order 0, 2, 1, 3
  function automatic logic [SW-1:0] f_slot(input logic [8:0] a);
    logic [1:0] op;
    op = {a[2], a[3]};
    return SW'(op * NUM_CH) + SW'(f_ch(a));
  endfunction

  function automatic logic f_op(input logic [8:0] a);
    return (a[7:4] >= 4'd3) && (a[7:4] <= 4'd9);
  endfunction

  typedef enum logic {S_IDLE, S_PEND} st_t;
  st_t st, st_nx;

  logic [8:0]    adr;
  logic          adr_vld;
  logic [8:0]    p_adr;
  logic [7:0]    p_dat;
  logic          ovf_q;
  logic [CW-1:0] cur_ch;

  logic [7:0]  op_mem   [NSLOT][7];
  logic [10:0] fnum_mem [NUM_CH];
  logic [2:0]  blk_mem  [NUM_CH];
  logic [5:0]  b0_mem   [NUM_CH];
  logic [7:0]  b4_mem   [NUM_CH];
  logic [5:0]  hold     [2];

  logic [3:0]    tch;
  logic          ch_ok;
  logic [SW-1:0] tslot;
  logic [2:0]    oreg;
  logic          is_op, is_chr;
  logic          is_fl, is_fh, is_b0, is_b4;

  assign tch    = f_ch(p_adr);
  assign ch_ok  = f_ok(p_adr);
  assign tslot  = f_slot(p_adr);
  assign oreg   = 3'(p_adr[7:4] - 4'd3);
  assign is_op  = f_op(p_adr);
  assign is_chr = (p_adr[7:0] >= 8'hA0) && (p_adr[7:0] <= 8'hB7);
  assign is_fl  = p_adr[7:2] == 6'h28;
  assign is_fh  = p_adr[7:2] == 6'h29;
  assign is_b0  = p_adr[7:2] == 6'h2C;
  assign is_b4  = p_adr[7:2] == 6'h2D;

  logic bsy, acc_op, acc_ch, done;
  logic aw_ok, dw, dw_ok, dw_drop;

  assign bsy    = st == S_PEND;
  assign acc_op = bsy && slot_en && ch_ok && is_op && (slot == tslot);
  assign acc_ch = bsy && slot_en && ch_ok && is_chr
                  && (cur_ch == tch[CW-1:0]);
  // targets with nowhere to land retire on the first slot_en
  assign done   = acc_op || acc_ch
                  || (bsy && slot_en && !(ch_ok && (is_op || is_chr)));

  // address strobe wins when both strobes coincide
  assign aw_ok   = bus.addr_wr && (bus.din[7:4] != 4'd0);
  assign dw      = bus.data_wr && !bus.addr_wr;
  assign dw_ok   = dw && adr_vld && !bsy;
  assign dw_drop = dw && bsy;

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE:  if (dw_ok) st_nx = S_PEND;
      S_PEND:  if (done)  st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (st == S_PEND);
    bus.ovf  = ovf_q;
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      slot   <= '0;
      cur_ch <= '0;
    end else if (slot_sync) begin
      slot   <= '0;
      cur_ch <= '0;
    end else if (slot_en) begin
      slot   <= (slot == SW'(NSLOT - 1)) ? '0 : slot + SW'(1);
      cur_ch <= (cur_ch == CW'(NUM_CH - 1)) ? '0 : cur_ch + CW'(1);
    end
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      adr     <= '0;
      adr_vld <= 1'b0;
      p_adr   <= '0;
      p_dat   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= dw_drop;
      if (aw_ok) begin
        adr     <= {bus.bank, bus.din};
        adr_vld <= 1'b1;
      end
      // target is captured with the data so a later address
      // strobe cannot redirect a pending write
      if (dw_ok) begin
        p_adr <= adr;
        p_dat <= bus.din;
      end
    end
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++)
        for (int j = 0; j < 7; j++)
          op_mem[i][j] <= '0;
    end else if (acc_op) begin
      op_mem[tslot][oreg] <= p_dat;
    end
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        fnum_mem[i] <= '0;
        blk_mem[i]  <= '0;
        b0_mem[i]   <= '0;
        b4_mem[i]   <= 8'hC0;
      end
      hold[0] <= '0;
      hold[1] <= '0;
    end else if (acc_ch) begin
      unique case (1'b1)
        is_fl: begin
          fnum_mem[tch[CW-1:0]] <= {hold[p_adr[8]][2:0], p_dat};
          blk_mem[tch[CW-1:0]]  <= hold[p_adr[8]][5:3];
        end
        is_fh:   hold[p_adr[8]]      <= p_dat[5:0];
        is_b0:   b0_mem[tch[CW-1:0]] <= p_dat[5:0];
        is_b4:   b4_mem[tch[CW-1:0]] <= p_dat;
        default: ;
      endcase
    end
  end

  always_comb begin
    op_regs = '0;
    for (int j = 0; j < 7; j++)
      op_regs[j*8 +: 8] = op_mem[slot][j];
  end

  assign ch_fnum  = fnum_mem[cur_ch];
  assign ch_block = blk_mem[cur_ch];
  assign ch_b0    = b0_mem[cur_ch];
  assign ch_b4    = b4_mem[cur_ch];

`ifdef YM3438_REG_READBACK_EN
  logic [3:0] rch;
  logic [7:0] rbyte;

  assign rch = f_ch(adr);

  always_comb begin
    rbyte = 8'h00;
    if (f_ok(adr)) begin
      unique case (1'b1)
        f_op(adr):
          rbyte = op_mem[f_slot(adr)][3'(adr[7:4] - 4'd3)];
        adr[7:2] == 6'h28:
          rbyte = fnum_mem[rch[CW-1:0]][7:0];
        adr[7:2] == 6'h29:
          rbyte = {2'b00, blk_mem[rch[CW-1:0]],
                   fnum_mem[rch[CW-1:0]][10:8]};
        adr[7:2] == 6'h2C:
          rbyte = {2'b00, b0_mem[rch[CW-1:0]]};
        adr[7:2] == 6'h2D:
          rbyte = b4_mem[rch[CW-1:0]];
        default: rbyte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge MCLK or posedge rst) begin
    if (rst)         rd_data <= 8'h00;
    else if (rd_req) rd_data <= rbyte;
  end
`endif

endmodule
